cordic_rotation_seq: RTL and testbench

Sequential CORDIC engine in rotation mode, the inverse direction of the existing vectoring stage. The vectoring stage drives y to zero and accumulates an angle. This block takes a vector and a target angle, drives the residual angle toward zero, and outputs the rotated vector. It is the sin/cos and rotate path of the scalable CORDIC datapath and uses the same 17-bit vector and 16-bit scaled-angle formats. One iteration runs per clock, with a start/done handshake.

---
 rtl/cordic_rotation_seq_if.sv | 37 +++
 rtl/cordic_rotation_seq.sv | 124 ++++++++++++
 tb/tb_cordic_rotation_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cordic_rotation_seq_if.sv
// Handshake and data bundle for the sequential rotation-mode CORDIC engine.
// The master drives the request and operands; the slave returns status and the rotated vector.
interface cordic_rotation_seq_if;
    logic               start;
    logic signed [16:0] x_in;
    logic signed [16:0] y_in;
    logic signed [15:0] angle_in;
    logic               busy;
    logic               done;
    logic signed [16:0] x_out;
    logic signed [16:0] y_out;
    logic signed [15:0] residual_out;

    modport master (
        output start,
        output x_in,
        output y_in,
        output angle_in,
        input  busy,
        input  done,
        input  x_out,
        input  y_out,
        input  residual_out
    );

    modport slave (
        input  start,
        input  x_in,
        input  y_in,
        input  angle_in,
        output busy,
        output done,
        output x_out,
        output y_out,
        output residual_out
    );
endinterface

// File: rtl/cordic_rotation_seq.sv
// Sequential rotation-mode CORDIC, one micro-rotation per clock, 8 iterations, start/done handshake.
// Define CORDIC_GAIN_COMP_EN to add a one-cycle 1/K gain-compensation state (latency 10 vs 9).
module cordic_rotation_seq (
    input  logic                 clk,
    input  logic                 rst,
    cordic_rotation_seq_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIter, StComp, StDone} state_e;

    state_e             state_q;
    logic [2:0]         iter_q;
    logic signed [16:0] x_q;
    logic signed [16:0] y_q;
    logic signed [15:0] z_q;

    logic signed [16:0] x_sh;
    logic signed [16:0] y_sh;
    logic signed [15:0] atan_val;
    logic signed [16:0] x_rot;
    logic signed [16:0] y_rot;
    logic signed [15:0] z_rot;

    // atan(2^-i) in the 0x4000 = 45 degree scaled-angle format
    function automatic logic signed [15:0] atan_lut(input logic [2:0] idx);
        logic signed [15:0] val;
        case (idx)
            3'd0:    val = 16'sh4000;
            3'd1:    val = 16'sh25C8;
            3'd2:    val = 16'sh13F6;
            3'd3:    val = 16'sh0A22;
            3'd4:    val = 16'sh0516;
            3'd5:    val = 16'sh028C;
            3'd6:    val = 16'sh0146;
            default: val = 16'sh00A3;
        endcase
        return val;
    endfunction

`ifdef CORDIC_GAIN_COMP_EN
    // v * (2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13) ~= v / 1.64676
    function automatic logic signed [16:0] gain_comp(input logic signed [16:0] v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9) - (v >>> 13);
    endfunction
`endif

    always_comb begin
        x_sh     = x_q >>> iter_q;
        y_sh     = y_q >>> iter_q;
        atan_val = atan_lut(iter_q);
        x_rot    = x_q;
        y_rot    = y_q;
        z_rot    = z_q;
        // Rotate toward the residual angle: sign of z picks the direction
        if (!z_q[15]) begin
            x_rot = x_q - y_sh;
            y_rot = y_q + x_sh;
            z_rot = z_q - atan_val;
        end else begin
            x_rot = x_q + y_sh;
            y_rot = y_q - x_sh;
            z_rot = z_q + atan_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            iter_q           <= 3'd0;
            x_q              <= '0;
            y_q              <= '0;
            z_q              <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.x_out        <= '0;
            bus.y_out        <= '0;
            bus.residual_out <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        x_q      <= bus.x_in;
                        y_q      <= bus.y_in;
                        z_q      <= bus.angle_in;
                        iter_q   <= 3'd0;
                        bus.busy <= 1'b1;
                        state_q  <= StIter;
                    end
                end
                StIter: begin
                    x_q    <= x_rot;
                    y_q    <= y_rot;
                    z_q    <= z_rot;
                    iter_q <= iter_q + 3'd1;
                    if (iter_q == 3'd7) begin
`ifdef CORDIC_GAIN_COMP_EN
                        state_q <= StComp;
`else
                        state_q <= StDone;
`endif
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                StComp: begin
                    x_q     <= gain_comp(x_q);
                    y_q     <= gain_comp(y_q);
                    state_q <= StDone;
                end
`endif
                StDone: begin
                    bus.x_out        <= x_q;
                    bus.y_out        <= y_q;
                    bus.residual_out <= z_q;
                    bus.done         <= 1'b1;
                    bus.busy         <= 1'b0;
                    state_q          <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rotation_seq.sv
// Directed bench for cordic_rotation_seq: reset, four rotations, start-while-busy and abort.
// Expected vectors are worked through the 8 iterations by hand (and the 1/K shift-add when enabled).
module tb_cordic_rotation_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cordic_rotation_seq_if bus ();

    cordic_rotation_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef CORDIC_GAIN_COMP_EN
    localparam int Lat   = 10;
    localparam int A0X   = 10001, A0Y  = 70;
    localparam int A45X  = 7122,  A45Y = 7023;
    localparam int AM45X = 7022,  AM45Y = -7121;
    localparam int A90X  = 70,    A90Y = 10001;
`else
    localparam int Lat   = 9;
    localparam int A0X   = 16468, A0Y  = 115;
    localparam int A45X  = 11727, A45Y = 11563;
    localparam int AM45X = 11560, AM45Y = -11727;
    localparam int A90X  = 115,   A90Y = 16468;
`endif
    localparam int A0Z = -147, A45Z = 149, AM45Z = 149, A90Z = 146;

    int n_vec = 0;
    int n_err = 0;
    int lat;
    int dones;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic signed [16:0] x, input logic signed [16:0] y,
                            input logic signed [15:0] a);
        bus.x_in     = x;
        bus.y_in     = y;
        bus.angle_in = a;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    // Returns number of edges after the accepting edge until done is seen (bounded)
    task automatic wait_done(input int from, output int l);
        l = from;
        while (bus.done !== 1'b1 && l < 40) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic check_out(input string tag, input int ex, input int ey, input int ez);
        check({tag, ".x_out"}, bus.x_out, ex);
        check({tag, ".y_out"}, bus.y_out, ey);
        check({tag, ".residual"}, bus.residual_out, ez);
    endtask

    task automatic run_vec(input string tag, input logic signed [16:0] x,
                           input logic signed [16:0] y, input logic signed [15:0] a,
                           input int ex, input int ey, input int ez);
        start_op(x, y, a);
        check({tag, ".busy_after_start"}, bus.busy, 1);
        wait_done(0, lat);
        check({tag, ".latency"}, lat, Lat);
        check({tag, ".busy_in_done"}, bus.busy, 0);
        check_out(tag, ex, ey, ez);
        @(negedge clk);
        check({tag, ".done_one_cycle"}, bus.done, 0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.x_in     = '0;
        bus.y_in     = '0;
        bus.angle_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done, 0);
        check_out("rst", 0, 0, 0);

        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check("idle.no_done", dones, 0);
        check("idle.busy", bus.busy, 0);

        run_vec("a0", 17'sd10000, 17'sd0, 16'sh0000, A0X, A0Y, A0Z);
        repeat (4) @(negedge clk);
        check_out("a0.held", A0X, A0Y, A0Z);

        run_vec("a45", 17'sd10000, 17'sd0, 16'sh4000, A45X, A45Y, A45Z);
        run_vec("am45", 17'sd10000, 17'sd0, 16'shC000, AM45X, AM45Y, AM45Z);
        run_vec("a90", 17'sd10000, 17'sd0, 16'sh7FFF, A90X, A90Y, A90Z);

        // Second start at cycle 3 is ignored, then held through done and accepted
        start_op(17'sd10000, 17'sd0, 16'sh7FFF);
        repeat (2) @(negedge clk);
        bus.x_in     = 17'sd10000;
        bus.y_in     = 17'sd0;
        bus.angle_in = 16'sh0000;
        bus.start    = 1'b1;
        wait_done(2, lat);
        check("b2b.first_latency", lat, Lat);
        check_out("b2b.first", A90X, A90Y, A90Z);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b.second_busy", bus.busy, 1);
        check("b2b.single_done", bus.done, 0);
        wait_done(0, lat);
        check("b2b.second_latency", lat, Lat);
        check_out("b2b.second", A0X, A0Y, A0Z);
        @(negedge clk);

        // Abort at cycle 5; start in the first cycle after rst deasserts
        start_op(17'sd10000, 17'sd0, 16'sh4000);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.busy", bus.busy, 0);
        check("abort.done", bus.done, 0);
        check_out("abort", 0, 0, 0);
        start_op(17'sd10000, 17'sd0, 16'shC000);
        check("post_abort.busy", bus.busy, 1);
        wait_done(0, lat);
        check("post_abort.latency", lat, Lat);
        check_out("post_abort", AM45X, AM45Y, AM45Z);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
